// File: rtl/dispatch_pkg.sv
// Shared definitions for the ingress dispatcher: ctrl encodings, the
// end-of-packet test and the dispatcher state encoding.
package dispatch_pkg;

  localparam logic [7:0] CTRL_BOP  = 8'hFF;
  localparam logic [7:0] CTRL_BODY = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_TX   = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  // Any nonzero ctrl other than the bop marker closes a packet.
  function automatic logic is_eop(input logic [7:0] ctrl);
    return (ctrl != CTRL_BODY) && (ctrl != CTRL_BOP);
  endfunction

endpackage

// File: rtl/fwft_fifo.sv
// Show-ahead (first-word-fall-through) FIFO: the head entry is visible on
// rd_data whenever empty is low. Synchronous clear empties it in one cycle.
module fwft_fifo #(
  parameter int WIDTH            = 72,
  parameter int DEPTH_LOG2       = 5,
  parameter int PROG_FULL_MARGIN = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic             prog_full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] MARGIN_CNT = CW'(PROG_FULL_MARGIN);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  push;
  logic                  pop;

  // Writes into a full FIFO and reads from an empty one are discarded.
  assign push = wr_en && !full;
  assign pop  = rd_en && !empty;

  // Storage array write port.
  // NOTE: the storage array carries no reset; clear only rewinds the pointers,
  // so stale entries are unreachable and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // Pointer and occupancy bookkeeping; clear has priority over push/pop.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data   = mem_q[rd_ptr_q];
  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_CNT);
  assign prog_full = ((DEPTH_CNT - count_q) <= MARGIN_CNT);

endmodule

// File: rtl/in_dispatcher.sv
// Ingress dispatcher: buffers the upstream packet stream and hands whole
// packets to two cores in strict alternation over a req/ack/outrdy handshake.
// Words arriving outside a packet (no leading bop) are counted and dropped.
module in_dispatcher
  import dispatch_pkg::*;
#(
  parameter int DATA_WIDTH       = 64,
  parameter int CTRL_WIDTH       = 8,
  parameter int FIFO_DEPTH_LOG2  = 5,
  parameter int PROG_FULL_MARGIN = 4,
  parameter int DROP_CNT_WIDTH   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic [CTRL_WIDTH-1:0]     in_ctrl,
  input  logic                      in_wr,
  output logic                      in_rdy,
  output logic [DATA_WIDTH-1:0]     out_data0,
  output logic [DATA_WIDTH-1:0]     out_data1,
  output logic                      out_wr0,
  output logic                      out_wr1,
  output logic                      out_req0,
  output logic                      out_req1,
  input  logic                      out_ack0,
  input  logic                      out_ack1,
  output logic                      out_bop0,
  output logic                      out_bop1,
  output logic                      out_eop0,
  output logic                      out_eop1,
  input  logic                      out_outrdy0,
  input  logic                      out_outrdy1,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);

  logic [CTRL_WIDTH-1:0]          head_ctrl;
  logic [DATA_WIDTH-1:0]          head_data;
  logic                           fifo_empty;
  logic                           fifo_full;
  logic                           fifo_prog_full;
  logic                           fifo_pop;
  logic                           head_is_bop;
  logic                           head_is_eop;
  logic [1:0]                     ack;
  logic [1:0]                     outrdy;

  state_t                         state_q, state_d;
  logic                           curr_q, curr_d;
  logic [1:0]                     req_q, req_d;
  logic [1:0]                     wr_q, wr_d;
  logic [1:0]                     bop_q, bop_d;
  logic [1:0]                     eop_q, eop_d;
  logic [1:0][DATA_WIDTH-1:0]     data_q, data_d;
  logic [DROP_CNT_WIDTH-1:0]      drop_q, drop_d, drop_inc;
  logic                           in_rdy_q;

  fwft_fifo #(
    .WIDTH            (CTRL_WIDTH + DATA_WIDTH),
    .DEPTH_LOG2       (FIFO_DEPTH_LOG2),
    .PROG_FULL_MARGIN (PROG_FULL_MARGIN)
  ) u_fifo (
    .clk       (clk),
    .clear     (reset),
    .wr_en     (in_wr),
    .wr_data   ({in_ctrl, in_data}),
    .rd_en     (fifo_pop),
    .rd_data   ({head_ctrl, head_data}),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .prog_full (fifo_prog_full)
  );

  assign head_is_bop = (head_ctrl == CTRL_BOP);
  assign head_is_eop = is_eop(head_ctrl);
  assign ack         = {out_ack1, out_ack0};
  assign outrdy      = {out_outrdy1, out_outrdy0};
  assign drop_inc    = (drop_q == '1) ? drop_q : drop_q + 1'b1;

  // Next-state and next-output logic for the dispatch state machine.
  // NOTE: every target gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    curr_d   = curr_q;
    req_d    = req_q;
    wr_d     = '0;
    bop_d    = '0;
    eop_d    = '0;
    data_d   = data_q;
    drop_d   = drop_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (head_is_bop) begin
            req_d[curr_q] = 1'b1;
            state_d       = ST_REQ;
          end else begin
            fifo_pop = 1'b1;
            drop_d   = drop_inc;
            state_d  = ST_DROP;
          end
        end
      end
      ST_REQ: begin
        if (ack[curr_q]) state_d = ST_TX;
      end
      ST_TX: begin
        // A mid-packet bop is forwarded as-is; only eop ends the packet.
        if (!fifo_empty && outrdy[curr_q]) begin
          fifo_pop       = 1'b1;
          wr_d[curr_q]   = 1'b1;
          data_d[curr_q] = head_data;
          bop_d[curr_q]  = head_is_bop;
          eop_d[curr_q]  = head_is_eop;
          if (head_is_eop) begin
            req_d[curr_q] = 1'b0;
            curr_d        = !curr_q;
            state_d       = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (!fifo_empty) begin
          if (head_is_bop) begin
            state_d = ST_IDLE;
          end else begin
            fifo_pop = 1'b1;
            drop_d   = drop_inc;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, registered core-side outputs, drop counter and in_rdy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      curr_q   <= 1'b0;
      req_q    <= '0;
      wr_q     <= '0;
      bop_q    <= '0;
      eop_q    <= '0;
      data_q   <= '0;
      drop_q   <= '0;
      in_rdy_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      curr_q   <= curr_d;
      req_q    <= req_d;
      wr_q     <= wr_d;
      bop_q    <= bop_d;
      eop_q    <= eop_d;
      data_q   <= data_d;
      drop_q   <= drop_d;
      in_rdy_q <= !fifo_prog_full;
    end
  end

  assign in_rdy     = in_rdy_q;
  assign out_data0  = data_q[0];
  assign out_data1  = data_q[1];
  assign out_wr0    = wr_q[0];
  assign out_wr1    = wr_q[1];
  assign out_req0   = req_q[0];
  assign out_req1   = req_q[1];
  assign out_bop0   = bop_q[0];
  assign out_bop1   = bop_q[1];
  assign out_eop0   = eop_q[0];
  assign out_eop1   = eop_q[1];
  assign drop_count = drop_q;

endmodule

// File: tb/tb_in_dispatcher.sv
// Directed bench for in_dispatcher. A protocol model assigns each driven word
// to the core it must reach and queues it; a negedge monitor pops and compares
// every word the DUT emits.
module tb_in_dispatcher;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] in_data = '0;
  logic [7:0]  in_ctrl = '0;
  logic        in_wr = 1'b0;
  logic        in_rdy;
  logic [63:0] out_data0, out_data1;
  logic        out_wr0, out_wr1, out_req0, out_req1;
  logic        out_ack0, out_ack1;
  logic        out_bop0, out_bop1, out_eop0, out_eop1;
  logic        out_outrdy0 = 1'b1;
  logic        out_outrdy1 = 1'b1;
  logic [15:0] drop_count;
  logic        ack_auto0 = 1'b1;
  logic        ack_auto1 = 1'b1;

  typedef struct packed {
    logic        bop;
    logic        eop;
    logic [63:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t mon_e0, mon_e1;
  int   checks = 0;
  int   failures = 0;
  bit   model_port = 1'b0;
  bit   model_in_pkt = 1'b0;

  always #5 clk = ~clk;

  // Cores grant as soon as they are offered a packet, unless held off.
  assign out_ack0 = ack_auto0 & out_req0;
  assign out_ack1 = ack_auto1 & out_req1;

  in_dispatcher dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_ctrl     (in_ctrl),
    .in_wr       (in_wr),
    .in_rdy      (in_rdy),
    .out_data0   (out_data0),
    .out_data1   (out_data1),
    .out_wr0     (out_wr0),
    .out_wr1     (out_wr1),
    .out_req0    (out_req0),
    .out_req1    (out_req1),
    .out_ack0    (out_ack0),
    .out_ack1    (out_ack1),
    .out_bop0    (out_bop0),
    .out_bop1    (out_bop1),
    .out_eop0    (out_eop0),
    .out_eop1    (out_eop1),
    .out_outrdy0 (out_outrdy0),
    .out_outrdy1 (out_outrdy1),
    .drop_count  (drop_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one word once in_rdy allows it; record where it must come out.
  task automatic push_word(input logic [7:0] ctrl, input logic [63:0] data);
    int   waited = 0;
    exp_t e;
    while (in_rdy !== 1'b1 && waited < 200) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (waited >= 200) check("push_in_rdy_timeout", 64'(in_rdy), 64'd1);
    e.bop  = (ctrl == 8'hFF);
    e.eop  = (ctrl != 8'h00) && (ctrl != 8'hFF);
    e.data = data;
    if (model_in_pkt || ctrl == 8'hFF) begin
      model_in_pkt = 1'b1;
      if (model_port == 1'b0) q0.push_back(e);
      else q1.push_back(e);
      if (e.eop) begin
        model_in_pkt = 1'b0;
        model_port   = !model_port;
      end
    end
    in_wr   = 1'b1;
    in_ctrl = ctrl;
    in_data = data;
    @(posedge clk);
    #1;
    in_wr = 1'b0;
  endtask

  task automatic send_pkt(input int n);
    for (int i = 0; i < n; i++) begin
      push_word((i == 0) ? 8'hFF : ((i == n - 1) ? 8'h01 : 8'h00), {$urandom, $urandom});
    end
  endtask

  task automatic drain(input string tag);
    int waited = 0;
    while ((q0.size() != 0 || q1.size() != 0) && waited < 300) begin
      @(posedge clk);
      #1;
      waited++;
    end
    cycles(2);
    check(tag, 64'(q0.size() + q1.size()), 64'd0);
  endtask

  // Every emitted word must be the next one expected on that port, with
  // req still high except on the eop word, where it drops together.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_wr0) begin
        if (q0.size() == 0) check("p0_unexpected_wr", 64'(out_wr0), 64'd0);
        else begin
          mon_e0 = q0.pop_front();
          check("p0_data", out_data0, mon_e0.data);
          check("p0_flags", 64'({out_bop0, out_eop0, out_req0}),
                64'({mon_e0.bop, mon_e0.eop, !mon_e0.eop}));
        end
      end
      if (out_wr1) begin
        if (q1.size() == 0) check("p1_unexpected_wr", 64'(out_wr1), 64'd0);
        else begin
          mon_e1 = q1.pop_front();
          check("p1_data", out_data1, mon_e1.data);
          check("p1_flags", 64'({out_bop1, out_eop1, out_req1}),
                64'({mon_e1.bop, mon_e1.eop, !mon_e1.eop}));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_flags", 64'({out_req0, out_req1, out_wr0, out_wr1, out_bop0, out_bop1,
                            out_eop0, out_eop1}), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_in_rdy", 64'(in_rdy), 64'd1);

    // Two back-to-back 4-word packets: A on port 0, B on port 1.
    send_pkt(4);
    send_pkt(4);
    drain("t1_drain");
    check("t1_req_idle", 64'({out_req0, out_req1}), 64'd0);

    // 6-word packet on port 0 with outrdy0 toggling 1,0,1,0...
    out_outrdy0 = 1'b0;
    send_pkt(6);
    cycles(4);
    begin
      int rem = 6;
      bit v   = 1'b1;
      @(negedge clk);
      out_outrdy0 = v;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        check("t2_wr_lag", 64'(out_wr0), 64'(v && rem > 0));
        if (v && rem > 0) rem--;
        v = !v;
        out_outrdy0 = v;
      end
    end
    out_outrdy0 = 1'b1;
    drain("t2_drain");

    // Port 1 withholds ack while the FIFO fills toward prog_full.
    ack_auto1 = 1'b0;
    push_word(8'hFF, {$urandom, $urandom});
    for (int i = 0; i < 27; i++) push_word(8'h00, {$urandom, $urandom});
    cycles(20);
    check("t3_req1_held", 64'(out_req1), 64'd1);
    check("t3_req0_idle", 64'(out_req0), 64'd0);
    check("t3_in_rdy_low", 64'(in_rdy), 64'd0);
    check("t3_nothing_moved", 64'(q1.size()), 64'd28);
    ack_auto1 = 1'b1;
    push_word(8'h00, {$urandom, $urandom});
    push_word(8'h01, {$urandom, $urandom});
    drain("t3_drain");

    // Three stray body words are dropped; the following packet goes to port 0.
    for (int i = 0; i < 3; i++) push_word(8'h00, {$urandom, $urandom});
    send_pkt(4);
    drain("t4_drain");
    check("t4_drop_count", 64'(drop_count), 64'd3);

    // Reset on word 2 of a 5-word packet headed for port 1.
    out_outrdy1 = 1'b0;
    push_word(8'hFF, {$urandom, $urandom});
    push_word(8'h00, {$urandom, $urandom});
    in_wr   = 1'b1;
    in_ctrl = 8'h00;
    in_data = {$urandom, $urandom};
    reset   = 1'b1;
    @(posedge clk);
    #1;
    in_wr = 1'b0;
    q0.delete();
    q1.delete();
    model_port   = 1'b0;
    model_in_pkt = 1'b0;
    @(negedge clk);
    check("t5_rst_flags", 64'({out_req0, out_req1, out_wr0, out_wr1, out_bop0, out_bop1,
                               out_eop0, out_eop1}), 64'd0);
    check("t5_rst_data0", out_data0, 64'd0);
    check("t5_rst_data1", out_data1, 64'd0);
    check("t5_rst_drop", 64'(drop_count), 64'd0);
    @(posedge clk);
    #1;
    reset       = 1'b0;
    out_outrdy1 = 1'b1;
    cycles(5);
    check("t5_fifo_empty", 64'({out_req0, out_req1, out_wr0, out_wr1}), 64'd0);
    check("t5_in_rdy", 64'(in_rdy), 64'd1);
    send_pkt(4);
    drain("t5_drain");

    // Lone bop word on port 1 keeps the dispatcher in TX until an eop arrives.
    push_word(8'hFF, {$urandom, $urandom});
    cycles(10);
    check("t6_bop_forwarded", 64'(q1.size()), 64'd0);
    check("t6_req1_held", 64'(out_req1), 64'd1);
    check("t6_req0_idle", 64'(out_req0), 64'd0);
    push_word(8'h01, {$urandom, $urandom});
    drain("t6_drain");
    check("t6_req1_drop", 64'(out_req1), 64'd0);

    // Next packet alternates back to port 0.
    send_pkt(3);
    drain("t7_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
